// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for the IF and MEM stages: data accesses win over fetches,
// each grant is held until mem_ack_i, and completions come back as registered one-cycle pulses.
// Define MEM_ARB_PERF_EN to add the saturating perf_conflict_o / perf_if_wait_o counters.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
`ifdef MEM_ARB_PERF_EN
  ,
  parameter int CNT_W  = 16
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              if_flush_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ready_o,
  input  logic              dm_read_i,
  input  logic              dm_write_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_ready_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              stall_if_o,
  output logic              stall_mem_o
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [CNT_W-1:0]  perf_conflict_o,
  output logic [CNT_W-1:0]  perf_if_wait_o
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_FETCH = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [DATA_W-1:0]   if_rdata_q;
  logic [DATA_W-1:0]   dm_rdata_q;
  logic                if_ready_q;
  logic                dm_ready_q;
  logic                kill_q;

  logic dm_req, dm_elig, if_elig;
  logic grant_data, grant_fetch;
  logic dm_done, if_done, if_deliver, dm_capture;

  // A requester whose ready pulse is high this cycle is still holding the old request.
  assign dm_req  = dm_read_i | dm_write_i;
  assign dm_elig = dm_req & ~dm_ready_q;
  assign if_elig = if_req_i & ~if_flush_i & ~if_ready_q;

  // NOTE: state and datapath registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: state_d gets a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (dm_elig) begin
          state_d = ST_DATA;
        end else if (if_elig) begin
          state_d = ST_FETCH;
        end
      end
      ST_DATA: begin
        if (mem_ack_i) begin
          state_d = if_elig ? ST_FETCH : ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (mem_ack_i) begin
          state_d = dm_elig ? ST_DATA : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_en_d    = (state_d != ST_IDLE);
    grant_data  = (state_d == ST_DATA)  && (state_q != ST_DATA);
    grant_fetch = (state_d == ST_FETCH) && (state_q != ST_FETCH);
    dm_done     = (state_q == ST_DATA)  && mem_ack_i;
    if_done     = (state_q == ST_FETCH) && mem_ack_i;
    dm_capture  = dm_done && !mem_we_q;
    // A flush landing on the ack cycle still kills the fetch being returned.
    if_deliver  = if_done && !(kill_q || if_flush_i);
  end

  // NOTE: every datapath flop is reset; a late ack after reset must find clean
  // address/strobe state, and there is no storage array here to exempt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
      kill_q      <= 1'b0;
    end else begin
      mem_en_q   <= mem_en_d;
      if_ready_q <= if_deliver;
      dm_ready_q <= dm_done;
      if (grant_data) begin
        mem_addr_q  <= dm_addr_i;
        mem_wdata_q <= dm_wdata_i;
        mem_we_q    <= dm_write_i;
      end else if (grant_fetch) begin
        mem_addr_q  <= if_addr_i;
        mem_we_q    <= 1'b0;
      end
      if (dm_capture) begin
        dm_rdata_q <= mem_rdata_i;
      end
      if (if_deliver) begin
        if_rdata_q <= mem_rdata_i;
      end
      // The fetch in flight cannot be aborted, so a flush only marks its result as dead.
      if (if_done) begin
        kill_q <= 1'b0;
      end else if ((state_q == ST_FETCH) && if_flush_i) begin
        kill_q <= 1'b1;
      end
    end
  end

  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign if_ready_o  = if_ready_q;
  assign dm_ready_o  = dm_ready_q;
  assign stall_if_o  = if_req_i & ~if_ready_q;
  assign stall_mem_o = dm_req & ~dm_ready_q;

`ifdef MEM_ARB_PERF_EN
  logic [CNT_W-1:0] perf_conflict_q;
  logic [CNT_W-1:0] perf_if_wait_q;
  logic             conflict_inc;

  assign conflict_inc = (state_q == ST_IDLE) & dm_elig & if_elig;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_conflict_q <= '0;
      perf_if_wait_q  <= '0;
    end else begin
      if (conflict_inc && (perf_conflict_q != '1)) begin
        perf_conflict_q <= perf_conflict_q + CNT_W'(1);
      end
      if (stall_if_o && (perf_if_wait_q != '1)) begin
        perf_if_wait_q <= perf_if_wait_q + CNT_W'(1);
      end
    end
  end

  assign perf_conflict_o = perf_conflict_q;
  assign perf_if_wait_o  = perf_if_wait_q;
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified instruction/data memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage pipelined CPU.
- Holds each granted transaction until the memory acknowledges it, returns read data through registered ready pulses, and raises per-stage stall lines.
- The hazard/stall logic ORs these stall lines into the pipeline freeze.
- Data accesses have priority over fetches, because the MEM-stage instruction is the older one.

Parameters:
- ADDR_W, 32, width of all addresses.
- DATA_W, 32, width of all data words.
- CNT_W, 16, width of performance counters (optional feature only).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request, held until if_ready.
- if_addr  in  ADDR_W  fetch address (PC).
- if_flush  in  1  kill the outstanding or pending fetch (taken branch/jump).
- if_rdata  out  DATA_W  fetched instruction, valid when if_ready=1.
- if_ready  out  1  one-cycle fetch completion pulse.
- dm_read  in  1  load request, held until dm_ready.
- dm_write  in  1  store request, held until dm_ready; dm_read and dm_write are never both 1.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  store data.
- dm_rdata  out  DATA_W  load data, valid when dm_ready=1.
- dm_ready  out  1  one-cycle data completion pulse.
- mem_en  out  1  memory transaction active.
- mem_we  out  1  write strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack.
- mem_ack  in  1  memory completion; any latency of 0 or more cycles after mem_en rises.
- stall_if  out  1  fetch waiting.
- stall_mem  out  1  data access waiting.

Behaviour:
- Reset: asynchronous, taken while RST=0. State goes to IDLE. All registered outputs clear: mem_en, mem_we, mem_addr, mem_wdata, if_rdata, dm_rdata, if_ready, dm_ready, kill flag. An outstanding transaction is abandoned, and a mem_ack arriving after reset release while in IDLE is ignored.
- FSM states: IDLE, DATA, FETCH. mem_en=1 exactly when the state is DATA or FETCH. mem_addr, mem_wdata and mem_we are registered at grant and held constant until ack.
- Request eligibility: a data request is eligible when (dm_read|dm_write) & !dm_ready. A fetch request is eligible when if_req & !if_flush & !if_ready. A requester whose ready pulse is high that cycle is ignored, which prevents re-issue of its held request.
- IDLE:
  - Eligible data request → DATA; latch dm_addr, dm_wdata, and mem_we=dm_write.
  - Otherwise, eligible fetch → FETCH; latch if_addr, mem_we=0.
  - Otherwise stay in IDLE.
- DATA, on mem_ack=1:
  - Capture mem_rdata into dm_rdata (loads only; unchanged on stores). dm_ready=1 in the next cycle.
  - Next state is FETCH if a fetch is eligible, latching if_addr in the same edge (back-to-back, no idle bubble). Otherwise IDLE.
- FETCH, on mem_ack=1:
  - Capture mem_rdata into if_rdata. if_ready=1 next cycle unless the kill flag is set.
  - Next state is DATA if a data request is eligible (back-to-back, latching it), else IDLE. The kill flag clears.
- Flush: if_flush=1 while in FETCH sets the kill flag. The memory transaction still completes, because memory cannot be aborted, but if_ready is suppressed and if_rdata is not updated. if_flush in IDLE simply blocks the fetch grant that cycle.
- Stall outputs are combinational: stall_if = if_req & !if_ready; stall_mem = (dm_read|dm_write) & !dm_ready.
- Minimum latency, request cycle to ready pulse: 2 cycles (grant edge, then ack edge, with a zero-wait memory).
- Simultaneous data and fetch requests in IDLE: data is served first, then the fetch back-to-back.
- A single registered ready pulse lasts exactly one cycle.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- Defined:
  - Adds outputs perf_conflict (CNT_W bits) and perf_if_wait (CNT_W bits).
  - perf_conflict increments on each IDLE cycle where both requests are eligible.
  - perf_if_wait increments on each cycle with stall_if=1.
  - Both counters saturate at all-ones and reset to 0 on RST.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Fetch only, if_addr=0x00000004, memory acks in the first DATA/FETCH cycle, mem_rdata=0x20010005 → mem_en high for 1 cycle, if_rdata=0x20010005, if_ready pulses exactly 2 cycles after if_req rises, then IDLE.
- Simultaneous dm_read@0x40 and if_req@0x08, memory latency 3 cycles → data granted first, dm_ready pulse, fetch issued on the same edge as the data ack, mem_en continuously high, if_ready follows.
- Store dm_write@0x10 with wdata 0xDEADBEEF → mem_we=1, mem_addr=0x10, mem_wdata=0xDEADBEEF held until ack; dm_rdata unchanged; stall_mem low in the dm_ready cycle.
- Flush during FETCH with 2-cycle latency → no if_ready pulse, if_rdata keeps its prior value, FSM returns to IDLE after ack, next if_req@0x20 is served normally.
- RST low mid-DATA, then a late mem_ack → all outputs 0 immediately; state IDLE; late ack produces no ready pulse.
- With MEM_ARB_PERF_EN: 3 simultaneous-request events → perf_conflict=3; counter preset near max saturates at 0xFFFF.
